if_fetch_queue: RTL and testbench

- Parametrised next-generation instruction-fetch stage.
- Owns the PC, issues fetch requests to the I-cache/imem, and waits on misses.
- Buffers fetched {pc, inst} pairs in a DEPTH-entry queue and hands them to decode through a valid/ready handshake.
- A redirect from EX (branch, jump or jr target already resolved) flushes the queue and restarts fetch at the new PC.

---
 rtl/if_fetch_queue_if.sv | 32 +++
 rtl/if_fetch_queue.sv | 116 +++++++++++
 tb/tb_if_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bundle: redirect from EX, I-cache/imem request port and decode handshake.
// The slave modport is the fetch stage's own view of the bundle.
interface if_fetch_queue_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_hit;
  logic [INST_W-1:0] imem_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;
  logic [31:0]       miss_cycles;

  modport slave (
    input  redirect_valid, redirect_pc, imem_hit, imem_inst, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_inst, count, miss_cycles
  );

  modport master (
    output redirect_valid, redirect_pc, imem_hit, imem_inst, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_inst, count, miss_cycles
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, fetches from imem (stalling on misses) and
// buffers {pc, inst} pairs in a DEPTH-entry FIFO towards decode; EX redirects flush it.
module if_fetch_queue #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic               clk,
  input logic               rst,
  if_fetch_queue_if.slave   bus
);
  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [PC_W-1:0] PC_MASK = ~(PC_W'(PC_STEP - 1));
  localparam logic [PC_W-1:0] PC_INC  = PC_W'(PC_STEP);

  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      miss_q, miss_d;
  entry_t           mem [DEPTH];

  logic out_valid, pop, space, req, push;

  always_comb begin
    out_valid = (count_q != '0) && !bus.redirect_valid;
    pop       = out_valid && bus.out_ready;
    space     = (count_q < CNT_W'(DEPTH)) || pop;
    req       = !rst && !bus.redirect_valid && space;
    push      = req && bus.imem_hit;
  end

  // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    miss_d   = miss_q;

    // Stall accounting covers every cycle spent in WAIT, flushed or not.
    if (state_q == ST_WAIT && miss_q != '1) begin
      miss_d = miss_q + 32'd1;
    end

    if (bus.redirect_valid) begin
      state_d  = ST_RUN;
      pc_d     = bus.redirect_pc & PC_MASK;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + PC_INC;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        state_d  = ST_RUN;
      end else if (req && state_q == ST_RUN) begin
        state_d = ST_WAIT;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC & PC_MASK;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      miss_q   <= miss_d;
    end
  end

  // NOTE: queue storage is not reset; count_q gates every read so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{pc: pc_q, inst: bus.imem_inst};
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = mem[rd_ptr_q].pc;
  assign bus.out_inst    = mem[rd_ptr_q].inst;
  assign bus.count       = count_q;
  assign bus.miss_cycles = miss_q;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (DEPTH=4, RESET_PC=0x100, PC_STEP=4): inputs change on
// the falling edge and outputs are sampled 1 ns later, well away from the rising edge.
module tb_if_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  if_fetch_queue_if #(.PC_W(32), .INST_W(32), .DEPTH(4)) bus ();

  if_fetch_queue #(
    .PC_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h100), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: the word returned depends only on the address.
  assign bus.imem_inst = inst_of(bus.imem_addr);

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_hit       = 1'b0;
    bus.out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_hit       = 1'b1;
    bus.out_ready      = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.miss_cycles !== 32'd0) begin n_err++; $display("FAIL reset_miss: got %0d want 0", bus.miss_cycles); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL reset_addr: got %h want 100", bus.imem_addr); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL reset_first_req: got %b want 1", bus.imem_req); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.imem_hit  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (bus.imem_addr !== 32'h100 + 32'(4 * k)) begin n_err++; $display("FAIL stream_addr[%0d]: got %h want %h", k, bus.imem_addr, 32'h100 + 32'(4 * k)); end
      n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL stream_req[%0d]: got %b want 1", k, bus.imem_req); end
      n_cmp++; if (bus.out_valid !== (k != 0)) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want %b", k, bus.out_valid, k != 0); end
      if (k != 0) begin
        n_cmp++; if (bus.out_pc !== 32'h100 + 32'(4 * (k - 1))) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.out_pc, 32'h100 + 32'(4 * (k - 1))); end
        n_cmp++; if (bus.out_inst !== inst_of(32'h100 + 32'(4 * (k - 1)))) begin n_err++; $display("FAIL stream_inst[%0d]: got %h", k, bus.out_inst); end
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL stream_count[%0d]: got %0d want 1", k, bus.count); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.imem_hit  = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (bus.imem_addr !== 32'h100 + 32'(4 * k)) begin n_err++; $display("FAIL full_fill_addr[%0d]: got %h", k, bus.imem_addr); end
      n_cmp++; if (bus.count !== 3'(k)) begin n_err++; $display("FAIL full_fill_count[%0d]: got %0d want %0d", k, bus.count, k); end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL full_count[%0d]: got %0d want 4", k, bus.count); end
      n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL full_req[%0d]: got %b want 0", k, bus.imem_req); end
      n_cmp++; if (bus.imem_addr !== 32'h110) begin n_err++; $display("FAIL full_addr[%0d]: got %h want 110", k, bus.imem_addr); end
      n_cmp++; if (bus.out_pc !== 32'h100) begin n_err++; $display("FAIL full_head[%0d]: got %h want 100", k, bus.out_pc); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL full_pop_req: got %b want 1", bus.imem_req); end
    @(negedge clk); #1;
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL full_pushpop_count: got %0d want 4", bus.count); end
    n_cmp++; if (bus.out_pc !== 32'h104) begin n_err++; $display("FAIL full_pushpop_head: got %h want 104", bus.out_pc); end
    n_cmp++; if (bus.imem_addr !== 32'h114) begin n_err++; $display("FAIL full_pushpop_addr: got %h want 114", bus.imem_addr); end
    bus.out_ready = 1'b0;
    bus.imem_hit  = 1'b0;
  endtask

  task automatic test_miss();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL miss_redir_req: got %b want 0", bus.imem_req); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.imem_hit = (k == 3);
      #1;
      n_cmp++; if (bus.imem_addr !== 32'h200) begin n_err++; $display("FAIL miss_addr[%0d]: got %h want 200", k, bus.imem_addr); end
      n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL miss_req[%0d]: got %b want 1", k, bus.imem_req); end
      @(negedge clk);
    end
    bus.imem_hit = 1'b0;
    #1;
    n_cmp++; if (bus.miss_cycles !== 32'd3) begin n_err++; $display("FAIL miss_cycles: got %0d want 3", bus.miss_cycles); end
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL miss_count: got %0d want 1", bus.count); end
    n_cmp++; if (bus.out_pc !== 32'h200) begin n_err++; $display("FAIL miss_pc: got %h want 200", bus.out_pc); end
    n_cmp++; if (bus.out_inst !== inst_of(32'h200)) begin n_err++; $display("FAIL miss_inst: got %h want %h", bus.out_inst, inst_of(32'h200)); end
    n_cmp++; if (bus.imem_addr !== 32'h204) begin n_err++; $display("FAIL miss_next_addr: got %h want 204", bus.imem_addr); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.imem_hit = 1'b1;
    repeat (3) @(negedge clk);
    bus.imem_hit = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL redir_pre_count: got %0d want 3", bus.count); end
    n_cmp++; if (bus.imem_addr !== 32'h10C) begin n_err++; $display("FAIL redir_pre_addr: got %h want 10c", bus.imem_addr); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL redir_pre_req: got %b want 1", bus.imem_req); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h403;
    bus.imem_hit       = 1'b1;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b want 0", bus.out_valid); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.imem_hit       = 1'b0;
    #1;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL redir_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_post_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.imem_addr !== 32'h400) begin n_err++; $display("FAIL redir_addr: got %h want 400", bus.imem_addr); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL redir_post_req: got %b want 1", bus.imem_req); end
    bus.imem_hit = 1'b1;
    @(negedge clk);
    bus.imem_hit = 1'b0;
    #1;
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL redir_fetch_count: got %0d want 1", bus.count); end
    n_cmp++; if (bus.out_pc !== 32'h400) begin n_err++; $display("FAIL redir_fetch_pc: got %h want 400", bus.out_pc); end
    n_cmp++; if (bus.imem_addr !== 32'h404) begin n_err++; $display("FAIL redir_fetch_addr: got %h want 404", bus.imem_addr); end
    // Two redirects on consecutive cycles: the later target is the one fetched.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h500;
    bus.imem_hit       = 1'b1;
    @(negedge clk);
    bus.redirect_pc = 32'h604;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL b2b_req: got %b want 0", bus.imem_req); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    n_cmp++; if (bus.imem_addr !== 32'h604) begin n_err++; $display("FAIL b2b_addr: got %h want 604", bus.imem_addr); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL b2b_req_after: got %b want 1", bus.imem_req); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL b2b_count: got %0d want 0", bus.count); end
    bus.imem_hit = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    logic [31:0] exp_pc;
    logic        pop, sp;
    int          pushes;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF0;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    exp_pc = 32'hFFFF_FFF0;
    pushes = 0;
    for (int k = 0; k < 16; k++) begin
      bus.imem_hit  = 1'b1;
      bus.out_ready = (k % 3 != 0);
      #1;
      n_cmp++; if (bus.imem_addr !== exp_pc) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, bus.imem_addr, exp_pc); end
      n_cmp++; if (bus.count !== 3'(q.size())) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want %0d", k, bus.count, q.size()); end
      n_cmp++; if (bus.out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL wrap_valid[%0d]: got %b want %b", k, bus.out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_cmp++; if (bus.out_pc !== q[0]) begin n_err++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, bus.out_pc, q[0]); end
      end
      pop = (q.size() != 0) && bus.out_ready;
      sp  = (q.size() < 4) || pop;
      n_cmp++; if (bus.imem_req !== sp) begin n_err++; $display("FAIL wrap_req[%0d]: got %b want %b", k, bus.imem_req, sp); end
      if (pop) void'(q.pop_front());
      if (sp) begin
        q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
        pushes++;
      end
      @(negedge clk);
    end
    bus.imem_hit  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6 && q.size() != 0; k++) begin
      #1;
      n_cmp++; if (bus.out_pc !== q[0]) begin n_err++; $display("FAIL wrap_drain_pc[%0d]: got %h want %h", k, bus.out_pc, q[0]); end
      n_cmp++; if (bus.out_inst !== inst_of(q[0])) begin n_err++; $display("FAIL wrap_drain_inst[%0d]: got %h want %h", k, bus.out_inst, inst_of(q[0])); end
      void'(q.pop_front());
      @(negedge clk);
    end
    #1;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL wrap_drained: got %0d want 0 after %0d pushes", bus.count, pushes); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.imem_hit = 1'b1;
    repeat (2) @(negedge clk);
    bus.imem_hit = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL rmid_pre_count: got %0d want 2", bus.count); end
    n_cmp++; if (bus.miss_cycles !== 32'd1) begin n_err++; $display("FAIL rmid_pre_miss: got %0d want 1", bus.miss_cycles); end
    n_cmp++; if (bus.imem_addr !== 32'h108) begin n_err++; $display("FAIL rmid_pre_addr: got %h want 108", bus.imem_addr); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.miss_cycles !== 32'd0) begin n_err++; $display("FAIL rmid_miss: got %0d want 0", bus.miss_cycles); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL rmid_addr: got %h want 100", bus.imem_addr); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rmid_post_req: got %b want 1", bus.imem_req); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_post_valid: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_miss();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
